// File: rtl/alu_issue_stage.sv
// RV64I decode/issue stage: decodes one instruction per cycle into ALU op/operands
// and holds the result in a single registered valid/ready slot feeding EX.
module alu_issue_stage #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_operand,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic [2:0]      br_funct3,
  output logic            illegal,
  output logic [15:0]     illegal_cnt
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    alu_op_e         operand;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic            illegal;
  } slot_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] SHAMT_MASK = {{(XLEN-SHAMT_W){1'b0}}, {SHAMT_W{1'b1}}};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  logic    f3_ok, f3_shift;
  alu_op_e f3_op;
  slot_t   dec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    f3_ok    = 1'b1;
    f3_op    = OP_ADD;
    f3_shift = 1'b0;
    unique case (funct3)
      3'b000:  f3_op = OP_ADD;
      3'b111:  f3_op = OP_AND;
      3'b110:  f3_op = OP_OR;
      3'b100:  f3_op = OP_XOR;
      3'b001:  begin f3_op = OP_SLL; f3_shift = 1'b1; end
      3'b101:  begin f3_op = OP_SRL; f3_shift = 1'b1; end
      default: f3_ok = 1'b0;  // slt/sltu and their immediate forms
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.rd        = instr[11:7];
    dec.illegal   = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec.op1       = rs1_data;
        dec.op2       = f3_shift ? (rs2_data & SHAMT_MASK) : rs2_data;
        dec.reg_write = 1'b1;
        if (funct7 == 7'h00) begin
          dec.operand = f3_op;
          dec.illegal = !f3_ok;
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          dec.operand = OP_SUB;
          dec.illegal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        dec.op1       = rs1_data;
        dec.op2       = f3_shift ? (imm_i & SHAMT_MASK) : imm_i;
        dec.operand   = f3_op;
        dec.reg_write = 1'b1;
        dec.illegal   = !f3_ok || (f3_shift && instr[31:26] != 6'b0);
      end
      OPC_LUI: begin
        dec.op2       = imm_u;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_AUIPC: begin
        dec.op1       = pc;
        dec.op2       = imm_u;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      OPC_LOAD: begin
        dec.op1       = rs1_data;
        dec.op2       = imm_i;
        dec.reg_write = 1'b1;
        dec.illegal   = (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.op1     = rs1_data;
        dec.op2     = imm_s;
        dec.illegal = funct3[2];
      end
      OPC_BRANCH: begin
        dec.op1       = rs1_data;
        dec.op2       = rs2_data;
        dec.operand   = OP_SUB;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        // Only eq/ne/lt/ge are resolvable from the zero/sign of a subtract.
        dec.illegal   = !(funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      end
      default: ;
    endcase
    if (dec.illegal) begin
      dec.op1       = '0;
      dec.op2       = '0;
      dec.operand   = OP_ADD;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.br_funct3 = 3'b000;
    end
  end

  logic        valid_q, valid_d;
  slot_t       slot_q, slot_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      slot_d  = dec;
      if (dec.illegal && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments; the data slot is reset too
  // because its outputs are visible to EX and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_op1     = slot_q.op1;
  assign alu_op2     = slot_q.op2;
  assign alu_operand = slot_q.operand;
  assign rd          = slot_q.rd;
  assign reg_write   = slot_q.reg_write;
  assign is_branch   = slot_q.is_branch;
  assign br_funct3   = slot_q.br_funct3;
  assign illegal     = slot_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_issue_stage;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc, rs1_data, rs2_data, alu_op1, alu_op2;
  logic [2:0]  alu_operand, br_funct3;
  logic [4:0]  rd;
  logic        reg_write, is_branch, illegal;
  logic [15:0] illegal_cnt;

  int checks   = 0;
  int failures = 0;

  alu_issue_stage #(.XLEN(64), .SHAMT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_operand(alu_operand), .rd(rd), .reg_write(reg_write), .is_branch(is_branch),
    .br_funct3(br_funct3), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] opc);
    return {imm, rs1, f3, rdi, opc};
  endfunction

  function automatic logic [31:0] b_type(input logic [2:0] f3);
    return {7'b0, 5'd2, 5'd1, f3, 5'b0, 7'b1100011};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_op1", alu_op1, 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3); rs1_data = 64'd5; rs2_data = 64'd7;
    in_valid = 1'b1;
    step();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_operand", 64'(alu_operand), 64'd0);
    check("add_op1", alu_op1, 64'd5);
    check("add_op2", alu_op2, 64'd7);
    check("add_rd", 64'(rd), 64'd3);
    check("add_rw", 64'(reg_write), 64'd1);
    check("add_stall_in_ready", 64'(in_ready), 64'd0);

    // SUB x4,x1,x2 loaded while ADD is consumed, then stalled 3 cycles
    instr = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4); rs1_data = 64'd2; rs2_data = 64'd9;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd8); rs1_data = 64'hAA; rs2_data = 64'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sub_stall_valid", 64'(out_valid), 64'd1);
      check("sub_stall_in_ready", 64'(in_ready), 64'd0);
      check("sub_stall_operand", 64'(alu_operand), 64'd1);
      check("sub_stall_op1", alu_op1, 64'd2);
      check("sub_stall_op2", alu_op2, 64'd9);
      check("sub_stall_rd", 64'(rd), 64'd4);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    check("sub_consumed", 64'(out_valid), 64'd0);

    // ADDI x5,x1,-1
    in_valid = 1'b1;
    instr = i_type(12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011); rs1_data = 64'h10;
    step();
    check("addi_op1", alu_op1, 64'h10);
    check("addi_op2", alu_op2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_operand", 64'(alu_operand), 64'd0);
    // SLL: only 6 shift bits survive
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd6); rs1_data = 64'hAA; rs2_data = 64'h47;
    step();
    check("sll_op2", alu_op2, 64'h07);
    check("sll_operand", 64'(alu_operand), 64'd5);
    check("sll_illegal", 64'(illegal), 64'd0);
    // SRLI shamt=0x25
    instr = i_type(12'h025, 5'd1, 3'b101, 5'd6, 7'b0010011);
    step();
    check("srli_op2", alu_op2, 64'h25);
    check("srli_operand", 64'(alu_operand), 64'd6);

    // AUIPC x7,0x12345 at pc=0x1000
    instr = {20'h12345, 5'd7, 7'b0010111}; pc = 64'h1000;
    step();
    check("auipc_op1", alu_op1, 64'h1000);
    check("auipc_op2", alu_op2, 64'h1234_5000);
    check("auipc_rw", 64'(reg_write), 64'd1);
    // LUI 0x80000: sign extends into the upper word
    instr = {20'h80000, 5'd7, 7'b0110111};
    step();
    check("lui_op1", alu_op1, 64'd0);
    check("lui_op2", alu_op2, 64'hFFFF_FFFF_8000_0000);
    // SD with imm=-4
    instr = {7'h7F, 5'd2, 5'd1, 3'b011, 5'h1C, 7'b0100011}; rs1_data = 64'h200;
    step();
    check("store_op2", alu_op2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("store_rw", 64'(reg_write), 64'd0);
    // BGE
    instr = b_type(3'b101); rs1_data = 64'd3; rs2_data = 64'd4;
    step();
    check("bge_operand", 64'(alu_operand), 64'd1);
    check("bge_is_branch", 64'(is_branch), 64'd1);
    check("bge_funct3", 64'(br_funct3), 64'd5);
    check("bge_rw", 64'(reg_write), 64'd0);
    check("bge_op2", alu_op2, 64'd4);

    // SLT, SRA, BLTU are all illegal
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd9);
    step();
    check("slt_illegal", 64'(illegal), 64'd1);
    check("slt_op1", alu_op1, 64'd0);
    check("slt_rw", 64'(reg_write), 64'd0);
    check("slt_cnt", 64'(illegal_cnt), 64'd1);
    instr = r_type(7'h20, 5'd2, 5'd1, 3'b101, 5'd9);
    step();
    check("sra_illegal", 64'(illegal), 64'd1);
    check("sra_operand", 64'(alu_operand), 64'd0);
    instr = b_type(3'b110);
    step();
    check("bltu_illegal", 64'(illegal), 64'd1);
    check("bltu_is_branch", 64'(is_branch), 64'd0);
    check("bltu_op2", alu_op2, 64'd0);
    check("illegal_cnt_3", 64'(illegal_cnt), 64'd3);

    // Drive the counter to 0xFFFF, then one more illegal must not wrap
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd9);
    repeat (65532) @(posedge clk);
    #1;
    check("cnt_at_max", 64'(illegal_cnt), 64'hFFFF);
    step();
    check("cnt_saturated", 64'(illegal_cnt), 64'hFFFF);

    // Flush with a held slot and an incoming instruction
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3); rs1_data = 64'd5; rs2_data = 64'd7;
    step();
    out_ready = 1'b0;
    step();
    check("preflush_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    instr = r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd11);
    step();
    check("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_dropped", 64'(out_valid), 64'd0);

    // Reset asserted mid-stall clears everything without a clock edge
    in_valid = 1'b1;
    instr = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4); rs1_data = 64'd2; rs2_data = 64'd9;
    step();
    in_valid = 1'b0;
    step();
    check("prereset_op2", alu_op2, 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_op2", alu_op2, 64'd0);
    check("midrst_op1", alu_op1, 64'd0);
    check("midrst_operand", 64'(alu_operand), 64'd0);
    check("midrst_rd", 64'(rd), 64'd0);
    check("midrst_cnt", 64'(illegal_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
